// File: rtl/prio_arbiter8_pkg.sv
// -----------------------------------------------------------------------------
// prio_arb_pkg
// Shared definitions for the 8-requester arbiter:
//   NREQ            - number of requesters (8)
//   ID_W            - width of a requester index (3)
//   arb_state_t     - arbiter FSM states (IDLE, GRANT)
//   onehot_from_id  - converts a requester index into a one-hot vector
// -----------------------------------------------------------------------------
package prio_arb_pkg;

    localparam int NREQ = 8;
    localparam int ID_W = 3;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    function automatic logic [NREQ-1:0] onehot_from_id(input logic [ID_W-1:0] id);
        logic [NREQ-1:0] one_s;
        one_s = 8'b0000_0001;
        return one_s << id;
    endfunction

endpackage

// File: rtl/prio_arbiter8_enc.sv
// -----------------------------------------------------------------------------
// prio_enc8
// Combinational 8:3 highest-set-bit encoder.
// Ports:
//   req [7:0] in  - request vector, bit 7 has highest priority
//   idx [2:0] out - index of the highest set bit (0 when none set)
//   any       out - high when at least one bit of req is set
// -----------------------------------------------------------------------------
module prio_enc8 (
    input  logic [7:0] req,
    output logic [2:0] idx,
    output logic       any
);

    // Highest set bit wins; casez gives an explicit priority order.
    always_comb begin
        idx = 3'd0;
        any = 1'b1;
        casez (req)
            8'b1???_????: idx = 3'd7;
            8'b01??_????: idx = 3'd6;
            8'b001?_????: idx = 3'd5;
            8'b0001_????: idx = 3'd4;
            8'b0000_1???: idx = 3'd3;
            8'b0000_01??: idx = 3'd2;
            8'b0000_001?: idx = 3'd1;
            8'b0000_0001: idx = 3'd0;
            default: begin
                idx = 3'd0;
                any = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/prio_arbiter8.sv
// -----------------------------------------------------------------------------
// prio_arbiter8
// Sequential 8-requester arbiter. Grants one requester at a time and holds
// the grant until the owner drops its request or MAX_HOLD cycles elapse,
// then re-arbitrates at the same edge (no bubble). The current owner is
// masked out of the arbitration that follows its release.
// Parameters:
//   MAX_HOLD      - max consecutive cycles of one grant (2..255)
// Ports:
//   clk           in   - clock, rising edge
//   rst           in   - asynchronous active-high reset
//   req     [7:0] in   - level requests, bit 7 highest fixed priority
//   gnt     [7:0] out  - one-hot grant (registered)
//   gnt_id  [2:0] out  - index of granted requester, valid with gnt_vld
//   gnt_vld       out  - a grant is active
//   timeout       out  - one-cycle pulse after a forced (MAX_HOLD) release
// Configuration:
//   PRIO_ARB_ROUND_ROBIN_EN - when defined, search starts below the last
//   granted index (ptr) and wraps, with ptr itself last. Undefined gives
//   pure fixed priority with no pointer register.
// -----------------------------------------------------------------------------
module prio_arbiter8
    import prio_arb_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_id,
    output logic       gnt_vld,
    output logic       timeout
);

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    arb_state_t      state_r, state_s;
    logic [7:0]      hold_cnt_r, hold_cnt_s;
    logic [NREQ-1:0] gnt_r, gnt_s;
    logic [ID_W-1:0] gnt_id_r, gnt_id_s;
    logic            gnt_vld_r, gnt_vld_s;
    logic            timeout_r, timeout_s;

    logic            owner_req_s;
    logic            hold_expired_s;
    logic [NREQ-1:0] cand_s;
    logic [NREQ-1:0] enc_in_s;
    logic [ID_W-1:0] enc_idx_s;
    logic            enc_any_s;
    logic [ID_W-1:0] win_id_s;

    // Owner status and the candidate set; the owner is excluded while granted.
    always_comb begin
        owner_req_s    = req[gnt_id_r];
        hold_expired_s = (hold_cnt_r == HOLD_LAST);
        if (state_r == GRANT) begin
            cand_s = req & ~onehot_from_id(gnt_id_r);
        end else begin
            cand_s = req;
        end
    end

`ifdef PRIO_ARB_ROUND_ROBIN_EN
    logic [ID_W-1:0]   ptr_r, ptr_s;
    logic [2*NREQ-1:0] cand_dbl_s;

    // Rotate so that bit 7 of the encoder input is requester ptr-1 and bit 0
    // is ptr itself; adding ptr back (mod 8) un-rotates the winning index.
    always_comb begin
        cand_dbl_s = {cand_s, cand_s} >> ptr_r;
        enc_in_s   = cand_dbl_s[NREQ-1:0];
        win_id_s   = enc_idx_s + ptr_r;
    end

    // Pointer follows every new grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_r <= 3'd0;
        end else begin
            ptr_r <= ptr_s;
        end
    end
`else
    // Fixed priority: encoder sees the candidates directly.
    always_comb begin
        enc_in_s = cand_s;
        win_id_s = enc_idx_s;
    end
`endif

    prio_enc8 u_enc (
        .req (enc_in_s),
        .idx (enc_idx_s),
        .any (enc_any_s)
    );

    // State register together with all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            hold_cnt_r <= 8'd0;
            gnt_r      <= 8'h00;
            gnt_id_r   <= 3'd0;
            gnt_vld_r  <= 1'b0;
            timeout_r  <= 1'b0;
        end else begin
            state_r    <= state_s;
            hold_cnt_r <= hold_cnt_s;
            gnt_r      <= gnt_s;
            gnt_id_r   <= gnt_id_s;
            gnt_vld_r  <= gnt_vld_s;
            timeout_r  <= timeout_s;
        end
    end

    // Next-state logic: new grant, hold, release with back-to-back hand-over.
    always_comb begin
        state_s    = state_r;
        hold_cnt_s = hold_cnt_r;
        gnt_s      = gnt_r;
        gnt_id_s   = gnt_id_r;
        gnt_vld_s  = gnt_vld_r;
        timeout_s  = 1'b0;
`ifdef PRIO_ARB_ROUND_ROBIN_EN
        ptr_s      = ptr_r;
`endif
        case (state_r)
            IDLE: begin
                if (enc_any_s) begin
                    state_s    = GRANT;
                    hold_cnt_s = 8'd0;
                    gnt_s      = onehot_from_id(win_id_s);
                    gnt_id_s   = win_id_s;
                    gnt_vld_s  = 1'b1;
`ifdef PRIO_ARB_ROUND_ROBIN_EN
                    ptr_s      = win_id_s;
`endif
                end else begin
                    state_s = IDLE;
                end
            end
            GRANT: begin
                if (!owner_req_s || hold_expired_s) begin
                    // Forced only if the owner still wants the resource.
                    timeout_s = owner_req_s;
                    if (enc_any_s) begin
                        state_s    = GRANT;
                        hold_cnt_s = 8'd0;
                        gnt_s      = onehot_from_id(win_id_s);
                        gnt_id_s   = win_id_s;
                        gnt_vld_s  = 1'b1;
`ifdef PRIO_ARB_ROUND_ROBIN_EN
                        ptr_s      = win_id_s;
`endif
                    end else begin
                        state_s    = IDLE;
                        hold_cnt_s = 8'd0;
                        gnt_s      = 8'h00;
                        gnt_id_s   = 3'd0;
                        gnt_vld_s  = 1'b0;
                    end
                end else begin
                    hold_cnt_s = hold_cnt_r + 8'd1;
                end
            end
            default: begin
                state_s    = IDLE;
                hold_cnt_s = 8'd0;
                gnt_s      = 8'h00;
                gnt_id_s   = 3'd0;
                gnt_vld_s  = 1'b0;
            end
        endcase
    end

    // Outputs come straight from registers; no path from req.
    always_comb begin
        gnt     = gnt_r;
        gnt_id  = gnt_id_r;
        gnt_vld = gnt_vld_r;
        timeout = timeout_r;
    end

endmodule

// File: tb/tb_prio_arbiter8.sv
// -----------------------------------------------------------------------------
// tb_prio_arbiter8
// Directed self-checking bench for prio_arbiter8 with MAX_HOLD=4.
// Default build exercises fixed priority; with PRIO_ARB_ROUND_ROBIN_EN
// defined it exercises the round-robin rotation instead.
// -----------------------------------------------------------------------------
module tb_prio_arbiter8;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_vld;
    logic       timeout;

    int checks_r   = 0;
    int failures_r = 0;

    prio_arbiter8 #(.MAX_HOLD(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .gnt_vld (gnt_vld),
        .timeout (timeout)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_r = checks_r + 1;
        if (obs !== exp) begin
            failures_r = failures_r + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_grant(input string tag, input logic [7:0] g, input logic [2:0] id,
                               input logic v, input logic to);
        check_val({tag, ".gnt"}, {24'd0, gnt}, {24'd0, g});
        if (v) check_val({tag, ".gnt_id"}, {29'd0, gnt_id}, {29'd0, id});
        check_val({tag, ".gnt_vld"}, {31'd0, gnt_vld}, {31'd0, v});
        check_val({tag, ".timeout"}, {31'd0, timeout}, {31'd0, to});
    endtask

    initial begin
        rst = 1'b1;
        req = 8'h00;
        #2;
        check_val("reset.gnt", {24'd0, gnt}, 32'h0);
        check_val("reset.gnt_id", {29'd0, gnt_id}, 32'h0);
        check_val("reset.gnt_vld", {31'd0, gnt_vld}, 32'h0);
        check_val("reset.timeout", {31'd0, timeout}, 32'h0);
        tick();
        check_val("reset_edge.gnt_vld", {31'd0, gnt_vld}, 32'h0);
        rst = 1'b0;
        tick();
        check_grant("idle_noreq", 8'h00, 3'd0, 1'b0, 1'b0);

`ifndef PRIO_ARB_ROUND_ROBIN_EN
        // Basic grant: highest set bit wins, then hand-over on voluntary drop.
        req = 8'h24;
        tick();
        check_grant("basic", 8'h20, 3'd5, 1'b1, 1'b0);
        req = 8'h04;
        tick();
        check_grant("basic_next", 8'h04, 3'd2, 1'b1, 1'b0);
        req = 8'h00;
        tick();
        check_grant("basic_idle", 8'h00, 3'd0, 1'b0, 1'b0);

        // Back-to-back: no gap between 7 and 0.
        req = 8'h81;
        tick();
        check_grant("b2b_first", 8'h80, 3'd7, 1'b1, 1'b0);
        req = 8'h01;
        tick();
        check_grant("b2b_second", 8'h01, 3'd0, 1'b1, 1'b0);
        req = 8'h00;
        tick();
        check_grant("b2b_idle", 8'h00, 3'd0, 1'b0, 1'b0);

        // Non-owner request changes do not disturb the grant.
        req = 8'hFF;
        tick();
        check_grant("nonowner_a", 8'h80, 3'd7, 1'b1, 1'b0);
        req = 8'h81;
        tick();
        check_grant("nonowner_b", 8'h80, 3'd7, 1'b1, 1'b0);
        req = 8'h00;
        tick();
        check_grant("nonowner_idle", 8'h00, 3'd0, 1'b0, 1'b0);

        // Timeout: owner 1 for exactly 4 cycles, then 0 with timeout pulse.
        req = 8'h03;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_grant("to_owner1", 8'h02, 3'd1, 1'b1, 1'b0);
        end
        tick();
        check_grant("to_switch0", 8'h01, 3'd0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_grant("to_owner0", 8'h01, 3'd0, 1'b1, 1'b0);
        end
        tick();
        check_grant("to_switch1", 8'h02, 3'd1, 1'b1, 1'b1);
        req = 8'h00;
        tick();
        check_grant("to_idle", 8'h00, 3'd0, 1'b0, 1'b0);

        // Idle return after a 3-cycle request pulse.
        req = 8'h08;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_grant("pulse_hold", 8'h08, 3'd3, 1'b1, 1'b0);
        end
        req = 8'h00;
        tick();
        check_grant("pulse_idle", 8'h00, 3'd0, 1'b0, 1'b0);

        // Async reset mid-grant clears outputs without a clock edge.
        req = 8'h10;
        tick();
        check_grant("areset_pre", 8'h10, 3'd4, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_grant("areset_async", 8'h00, 3'd0, 1'b0, 1'b0);
        tick();
        check_grant("areset_held", 8'h00, 3'd0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        check_grant("areset_regrant", 8'h10, 3'd4, 1'b1, 1'b0);
        req = 8'h00;
        tick();
        check_grant("areset_idle", 8'h00, 3'd0, 1'b0, 1'b0);
`else
        // Round-robin: all requesting, grants rotate 7 down to 0 then 7.
        begin
            logic [2:0] exp_id;
            logic [7:0] one_v;
            one_v = 8'h01;
            req = 8'hFF;
            for (int k = 0; k < 9; k++) begin
                exp_id = 3'(7 - (k % 8));
                for (int c = 0; c < 4; c++) begin
                    tick();
                    check_grant("rr", one_v << exp_id, exp_id, 1'b1,
                                (c == 0 && k != 0) ? 1'b1 : 1'b0);
                end
            end
            req = 8'h00;
            tick();
            tick();
            check_grant("rr_idle", 8'h00, 3'd0, 1'b0, 1'b0);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks_r, failures_r);
        $finish;
    end

endmodule

// File: doc/prio_arbiter8.md
# prio_arbiter8

Sequential 8-requester arbiter built around the team's 8:3 priority-encode function. It grants a shared resource to exactly one requester at a time and holds the grant until the owner releases it or a hold-timeout expires. It then re-arbitrates with no bubble cycle. It sits between up to eight initiators and one shared datapath resource (bus, memory port, etc.).

## Interface
- `MAX_HOLD`, default 16: maximum consecutive cycles one grant may be held; legal range 2..255.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req` in 8: per-requester request, level; bit 7 is the highest fixed priority.
- `gnt` out 8: one-hot grant, registered.
- `gnt_id` out 3: binary index of the granted requester; valid only while `gnt_vld` is high.
- `gnt_vld` out 1: high while any grant is active.
- `timeout` out 1: one-cycle pulse on the cycle a grant is revoked by `MAX_HOLD`.

## Operation
- States: `IDLE` and `GRANT`.
- `IDLE`:
  - If any `req` bit is high at an edge, latch the winner, load `hold_cnt`=0 and move to `GRANT`.
  - Otherwise stay in `IDLE`.
- `GRANT`, release conditions:
  - `req[gnt_id]`=0 (voluntary release), or
  - `hold_cnt`=`MAX_HOLD`-1 with `req[gnt_id]` still high (forced release; also pulses `timeout`).
- `GRANT`, no release: `hold_cnt` increments. It saturates only through the release rule and never wraps.
- `GRANT`, on release: arbitrate over `req` with the current owner's bit masked.
  - If a winner exists, grant it at the same edge (back-to-back), reset `hold_cnt`=0 and stay in `GRANT`.
  - If no winner exists, go to `IDLE` and clear `gnt`/`gnt_vld`.
- The masked owner may win again at the next arbitration if it still requests.
- Winner selection, fixed mode: highest set index wins, i.e. 8'b0010_0100 selects 5.
- Winner selection in round-robin mode: see Configuration.
- `req` bits of non-owners never affect the current grant.
- Exactly one `gnt` bit is high whenever `gnt_vld`=1. `gnt` is all-zero otherwise.
- Reset mid-grant: all outputs clear immediately (async). The next grant is issued no earlier than the first edge after `rst` deasserts.

## Timing
- Reset values:
  - `gnt`=8'h00, `gnt_id`=3'd0, `gnt_vld`=0, `timeout`=0.
  - State `IDLE`, `hold_cnt`=0, RR pointer=3'd0.
- Request-to-grant latency: 1 clock. A `req` sampled at edge N produces `gnt` valid after edge N.
- Release-to-next-grant: 0 idle cycles. Ownership changes at the single edge that samples the release.
- Forced release: a requester holding `req` continuously owns the grant for exactly `MAX_HOLD` cycles. `timeout` is high for the first cycle of the successor grant, or the first `IDLE` cycle.
- All outputs are registered; there is no combinational path from `req` to outputs.

## Configuration
- Macro: `PRIO_ARB_ROUND_ROBIN_EN`.
- Defined (round-robin mode):
  - A 3-bit pointer `ptr` updates to the granted index on every new grant.
  - Search order is `ptr`-1, `ptr`-2, … wrapping modulo 8, with `ptr` itself last.
  - With reset `ptr`=0, the first search order is 7..0, identical to fixed mode.
- Undefined: pure fixed priority (7 highest). No pointer register exists.

## Structure
- Package `prio_arb_pkg`:
  - `NREQ`=8, `ID_W`=3.
  - State enum `arb_state_t` {`IDLE`, `GRANT`}.
  - Function for one-hot-from-index.
- Sub-module `prio_enc8`: combinational 8:3 highest-set-bit encoder with an `any` output.
  - Round-robin is built by rotating the masked `req` by `ptr` before `prio_enc8` and un-rotating the index after it. The sub-module is shared by both modes.

## Test plan
- Reset/basic grant: `rst` pulse; `req`=8'h24 → after 1 edge `gnt`=8'h20, `gnt_id`=5, `gnt_vld`=1. Drop `req[5]` → next edge `gnt`=8'h04, `gnt_id`=2.
- Back-to-back release: `req`=8'h81; owner 7 drops `req[7]` → `gnt` changes 8'h80→8'h01 at one edge, with `gnt_vld` never low.
- Timeout: `MAX_HOLD`=4, `req`=8'h03 held → `gnt`=8'h02 for exactly 4 cycles. Then `gnt`=8'h01 with `timeout`=1 for one cycle. Then 8'h02 again after 4 more cycles.
- Idle return: single `req[3]` pulse of 3 cycles → grant for 3 cycles, then `gnt`=0, `gnt_vld`=0, state `IDLE`.
- Async reset mid-grant: assert `rst` between edges while `gnt`=8'h10 → `gnt`=0 and `gnt_vld`=0 without a clock edge.
- Round-robin (macro defined): `req`=8'hFF held, `MAX_HOLD`=2 → grant sequence 7,6,5,4,3,2,1,0,7.
